parser_input_arbiter: RTL
=========================

PARSER_INPUT_ARBITER -- requirements
Module: parser_input_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4, number of upstream requester ports (2..8).
REQ-002 Parameter STALL_LIMIT, default 256, consecutive idle cycles mid-packet before stall flag.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset_b  input  1  asynchronous, active-high reset (asserted = 1).
REQ-005 in_data  input  32*N_PORTS  per-port packet word, port k in bits [32k+31:32k].
REQ-006 in_val  input  N_PORTS  per-port word valid.
REQ-007 in_last  input  N_PORTS  per-port final word of packet.
REQ-008 in_ready  output  N_PORTS  per-port word accepted when in_val[k] & in_ready[k].
REQ-009 out_data  output  32  word to parser dataIn.
REQ-010 out_val  output  1  to parser dataIn_val.
REQ-011 out_last  output  1  to parser dataIN_last.
REQ-012 out_ready  input  1  from parser dataIn_ready.
REQ-013 grant_id  output  clog2(N_PORTS)  port currently owning the output.
REQ-014 busy  output  1  high while a packet is in flight (state BURST).
REQ-015 stall_err  output  1  sticky: granted port stalled mid-packet for STALL_LIMIT cycles.
REQ-016 pkt_count  output  16*N_PORTS  per-port count of completed packets, port k in [16k+15:16k].

Function
REQ-017 The block SHALL have two states, IDLE and BURST; arbitration is packet-granular, never word-granular.
REQ-018 In IDLE, out_val, out_last and all in_ready SHALL be 0; if any in_val is 1, the block SHALL register the winner into grant_id and enter BURST next cycle.
REQ-019 Winner SHALL be the first requesting port searching upward from (last_grant+1) mod N_PORTS, wrapping; last_grant resets to N_PORTS-1, so port 0 wins first.
REQ-020 In BURST, out_data/out_val/out_last SHALL combinationally equal in_data/in_val/in_last of grant_id; in_ready[grant_id] SHALL equal out_ready; all other in_ready SHALL be 0.
REQ-021 A transfer occurs when out_val & out_ready; on a transfer with out_last=1 the block SHALL return to IDLE next cycle, set last_grant=grant_id, increment pkt_count[grant_id].
REQ-022 Minimum cost SHALL be one idle arbitration cycle between packets; no zero-bubble back-to-back grants.
REQ-023 Requests arriving in BURST SHALL wait; grant SHALL never change before the last word transfers.
REQ-024 pkt_count fields SHALL be 16-bit unsigned and wrap 0xFFFF -> 0x0000 without flagging.
REQ-025 Stall counter SHALL clear on every cycle in_val[grant_id]=1 or in IDLE, else increment in BURST, saturating at STALL_LIMIT.
REQ-026 stall_err SHALL set when the stall counter reaches STALL_LIMIT and remain 1 until reset; the packet SHALL NOT be aborted.
REQ-027 out_ready low while out_val high SHALL hold the word; no word may be dropped or duplicated.
REQ-028 grant_id SHALL hold its value in IDLE (equal to last_grant).

Reset
REQ-029 On reset_b=1, regardless of state or mid-packet position: state=IDLE, out_val=0, out_last=0, in_ready=0, busy=0, stall_err=0, pkt_count all 0, stall counter 0, last_grant=N_PORTS-1, grant_id=N_PORTS-1.
REQ-030 out_data SHALL be 0 while in IDLE, including immediately after reset.
REQ-031 A packet interrupted by reset SHALL be discarded from arbiter state; upstream re-sends from its first word.

Structure
REQ-032 Shared package parser_pkg SHALL hold the state enum (IDLE, BURST), DATA_W=32, CNT_W=16.
REQ-033 Round-robin search SHALL be a sub-module rr_pick (inputs: request vector, last_grant; outputs: winner index, any_req).
REQ-034 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-035 Single port 0 sends 3-word packet, out_ready=1 -> grant_id=0 after one bubble, 3 transfers, pkt_count[0]=1, back to IDLE.
REQ-036 Ports 0,1,2 all request 2-word packets continuously -> grant order 0,1,2,0 with one idle cycle between packets.
REQ-037 Port 1 mid-packet, port 3 requests -> in_ready[3]=0 until port 1 last word transfers, then port 3 granted.
REQ-038 out_ready held 0 for 5 cycles during a word -> out_data stable, no in_ready pulse to port, word transferred once.
REQ-039 Granted port drops in_val for 256 cycles mid-packet -> stall_err=1 at cycle 256, stays 1 after packet completes.
REQ-040 reset_b pulsed mid-packet on port 2 -> all outputs reset values; next grant goes to lowest requesting port from 0.

Source files
------------

// File: rtl/parser_pkg.sv
// parser_pkg: shared types and widths for the parser input path.
//   state_t : arbiter packet state (IDLE between packets, BURST while one is in flight)
//   DATA_W  : parser word width
//   CNT_W   : per-port completed-packet counter width
package parser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search.
//   req       : per-port request vector
//   lastGrant : port that most recently completed a packet
//   winner    : first requesting port searching upward from lastGrant+1, wrapping
//   anyReq    : at least one request is present (winner is meaningful only then)
module rr_pick #(
  parameter  int N_PORTS = 4,
  localparam int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   lastGrant,
  output logic [IDX_W-1:0]   winner,
  output logic               anyReq
);

  int unsigned idx;

  // Scan offsets from farthest to nearest so the nearest requester after
  // lastGrant is the final assignment; avoids needing an early exit.
  always_comb begin
    winner = lastGrant;
    idx    = '0;
    for (int unsigned i = N_PORTS; i >= 1; i--) begin
      idx = (32'(lastGrant) + i) % N_PORTS;
      if (req[idx]) begin
        winner = IDX_W'(idx);
      end
    end
    anyReq = |req;
  end

endmodule

// File: rtl/parser_input_arbiter.sv
// parser_input_arbiter: packet-granular round-robin arbiter feeding the parser.
//   clk, reset_b          : clock, asynchronous active-high reset
//   in_data/in_val/in_last: per-port packet words (port k in slice k)
//   in_ready              : per-port accept, only the granted port sees out_ready
//   out_data/out_val/out_last, out_ready : parser dataIn handshake
//   grant_id              : port owning the output (holds last owner while idle)
//   busy                  : packet in flight
//   stall_err             : sticky, granted port idled STALL_LIMIT cycles mid-packet
//   pkt_count             : per-port wrapping count of completed packets
module parser_input_arbiter
  import parser_pkg::*;
#(
  parameter  int N_PORTS     = 4,
  parameter  int STALL_LIMIT = 256,
  localparam int IDX_W       = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic [DATA_W*N_PORTS-1:0] in_data,
  input  logic [N_PORTS-1:0]        in_val,
  input  logic [N_PORTS-1:0]        in_last,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_val,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      stall_err,
  output logic [CNT_W*N_PORTS-1:0]  pkt_count
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  state_t           state, nextState;
  logic [IDX_W-1:0] lastGrant, grantId, winner;
  logic             anyReq, xferLast;
  logic [SW-1:0]    stallCnt, stallCntNext;
  logic [CNT_W-1:0] pktCnt [N_PORTS];

  rr_pick #(.N_PORTS(N_PORTS)) uPick (
    .req      (in_val),
    .lastGrant(lastGrant),
    .winner   (winner),
    .anyReq   (anyReq)
  );

  always_comb begin
    nextState = state;
    out_data  = '0;
    out_val   = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    xferLast  = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) nextState = BURST;
      end
      BURST: begin
        out_data          = in_data[grantId*DATA_W +: DATA_W];
        out_val           = in_val[grantId];
        out_last          = in_last[grantId];
        in_ready[grantId] = out_ready;
        xferLast          = out_val & out_ready & out_last;
        if (xferLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    if (state == IDLE || in_val[grantId]) begin
      stallCntNext = '0;
    end else if (stallCnt == SW'(STALL_LIMIT)) begin
      stallCntNext = stallCnt;
    end else begin
      stallCntNext = stallCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state     <= IDLE;
      lastGrant <= IDX_W'(N_PORTS - 1);
      grantId   <= IDX_W'(N_PORTS - 1);
      stallCnt  <= '0;
      stall_err <= 1'b0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        pktCnt[k] <= '0;
      end
    end else begin
      state    <= nextState;
      stallCnt <= stallCntNext;
      if (stallCntNext == SW'(STALL_LIMIT)) stall_err <= 1'b1;
      if (state == IDLE && anyReq) grantId <= winner;
      if (xferLast) begin
        lastGrant       <= grantId;
        pktCnt[grantId] <= pktCnt[grantId] + 1'b1;
      end
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      pkt_count[k*CNT_W +: CNT_W] = pktCnt[k];
    end
  end

  assign grant_id = grantId;
  assign busy     = (state == BURST);

endmodule
